// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants, opcode encodings and the fixed-latency lookup.
// Contents:
//   REG_W, OP_W, LATW  register index, opcode and latency-counter widths
//   opcode_t, OP_*     opcode type and encodings used by the issue path
//   lat_of(op)         execute latency of an opcode; 0 means variable (await writeback)
package cpu_pkg;

    localparam int REG_W = 5;
    localparam int OP_W  = 6;
    localparam int LATW  = 3;

    typedef logic [OP_W-1:0] opcode_t;
    typedef logic [LATW-1:0] lat_t;

    localparam opcode_t OP_ADD = 6'h01;
    localparam opcode_t OP_SHF = 6'h02;
    localparam opcode_t OP_MUL = 6'h03;
    localparam opcode_t OP_DIV = 6'h04;
    localparam opcode_t OP_LD  = 6'h05;

    function automatic lat_t lat_of(input opcode_t op);
        case (op)
            OP_SHF:  return lat_t'(2);
            OP_MUL:  return lat_t'(3);
            OP_DIV:  return lat_t'(7);
            OP_LD:   return lat_t'(0);
            default: return lat_t'(1);
        endcase
    endfunction

endpackage

// File: rtl/sb_entry.sv
// sb_entry: pending state for one architectural register (pending, variable-latency, countdown).
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   flush_i    clear all state next cycle (beats every other input)
//   stall_i    freeze the countdown; writeback still honoured
//   set_i      issue accepted to this register this cycle
//   lat_i      latency of the issuing opcode (0 = variable)
//   wb_i       writeback addressed to this register this cycle
//   pend_o     register is pending (registered)
module sb_entry #(
    parameter int LATW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            set_i,
    input  logic [LATW-1:0] lat_i,
    input  logic            wb_i,
    output logic            pend_o
);

    logic            pend_q, pend_d;
    logic            var_q, var_d;
    logic [LATW-1:0] cnt_q, cnt_d;

    // The counter holds the number of cycles the register is still visible as
    // pending, so an issue with latency L is pending for L-1 cycles and reads
    // clear in cycle T+L; a latency of 1 is therefore never visible.
    always_comb begin
        pend_d = pend_q;
        var_d  = var_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            pend_d = 1'b0;
            var_d  = 1'b0;
            cnt_d  = '0;
        end else if (set_i) begin
            pend_d = lat_i != LATW'(1);
            var_d  = lat_i == '0;
            cnt_d  = lat_i == '0 ? '0 : lat_i - LATW'(1);
        end else if (wb_i && pend_q && var_q) begin
            pend_d = 1'b0;
            var_d  = 1'b0;
        end else if (!stall_i && pend_q && !var_q) begin
            cnt_d  = cnt_q - LATW'(1);
            pend_d = cnt_q != LATW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            var_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            var_q  <= var_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register in-flight write tracking with source-pending and WAW queries.
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   flush, stall                 squash all pending state / freeze execute
//   iss_valid, iss_dest_v,       instruction leaving the issue queue, its dest and opcode
//   iss_dest, iss_opcode
//   wb_valid, wb_reg             variable-latency writeback
//   q_src1, q_src2, q_dest       operands of the instruction being inserted
//   q_p1, q_p2, q_waw            pending bits for those operands (from current state)
//   busy_count                   number of pending registers
module register_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREG = 32,
    parameter int LATW = cpu_pkg::LATW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic             iss_valid,
    input  logic             iss_dest_v,
    input  logic [REG_W-1:0] iss_dest,
    input  logic [OP_W-1:0]  iss_opcode,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_reg,
    input  logic [REG_W-1:0] q_src1,
    input  logic [REG_W-1:0] q_src2,
    input  logic [REG_W-1:0] q_dest,
    output logic             q_p1,
    output logic             q_p2,
    output logic             q_waw,
    output logic [5:0]       busy_count
);

    logic [NREG-1:0] pend;
    logic            accept;
    logic [LATW-1:0] lat;

    assign accept = iss_valid && iss_dest_v && !stall && !flush && iss_dest != '0;
    assign lat    = LATW'(lat_of(iss_opcode));

    // Register 0 is hardwired clear so queries on it never report pending.
    assign pend[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_ent
        sb_entry #(.LATW(LATW)) u_ent (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .stall_i (stall),
            .set_i   (accept && iss_dest == REG_W'(g)),
            .lat_i   (lat),
            .wb_i    (wb_valid && wb_reg == REG_W'(g)),
            .pend_o  (pend[g])
        );
    end

    assign q_p1       = pend[q_src1];
    assign q_p2       = pend[q_src2];
    assign q_waw      = pend[q_dest];
    assign busy_count = 6'($countones(pend));

endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard: table-driven directed check of register_scoreboard plus reset sequences.
module tb_register_scoreboard;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst, flush, stall, iss_valid, iss_dest_v, wb_valid;
    logic [4:0] iss_dest, wb_reg, q_src1, q_src2, q_dest;
    logic [5:0] iss_opcode;
    logic       q_p1, q_p2, q_waw;
    logic [5:0] busy_count;

    int checks = 0;
    int errors = 0;

    register_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .stall      (stall),
        .iss_valid  (iss_valid),
        .iss_dest_v (iss_dest_v),
        .iss_dest   (iss_dest),
        .iss_opcode (iss_opcode),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .q_src1     (q_src1),
        .q_src2     (q_src2),
        .q_dest     (q_dest),
        .q_p1       (q_p1),
        .q_p2       (q_p2),
        .q_waw      (q_waw),
        .busy_count (busy_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fl, st, iv, idv;
        logic [4:0] id;
        logic [5:0] op;
        logic       wv;
        logic [4:0] wr, s1, s2, d;
        logic       p1, p2, w;
        logic [5:0] busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic fl, st, iv, idv, input logic [4:0] id,
                                input logic [5:0] op, input logic wv, input logic [4:0] wr,
                                input logic [4:0] s1, s2, d, input logic p1, p2, w,
                                input logic [5:0] busy);
        vec_t v;
        v = '{fl, st, iv, idv, id, op, wv, wr, s1, s2, d, p1, p2, w, busy};
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    task automatic idle();
        flush = 0; stall = 0; iss_valid = 0; iss_dest_v = 0; iss_dest = 0;
        iss_opcode = OP_ADD; wb_valid = 0; wb_reg = 0;
    endtask

    initial begin
        // fl st iv idv id op | wv wr | s1 s2 d | p1 p2 w busy
        tbl.push_back(mk(0,0,1,1, 7,OP_MUL, 0, 0,  7, 0, 7, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0,  7, 0, 7, 1,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0,  7, 0, 7, 1,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0,  7, 0, 7, 0,0,0,0));
        tbl.push_back(mk(0,0,1,1, 7,OP_SHF, 0, 0,  7, 8, 0, 0,0,0,0));
        tbl.push_back(mk(0,1,1,1, 8,OP_MUL, 0, 0,  7, 8, 8, 1,0,0,1));
        tbl.push_back(mk(0,1,0,0, 0,OP_ADD, 0, 0,  7, 8, 8, 1,0,0,1));
        tbl.push_back(mk(0,1,0,0, 0,OP_ADD, 0, 0,  7, 8, 8, 1,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0,  7, 8, 8, 1,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0,  7, 8, 8, 0,0,0,0));
        tbl.push_back(mk(0,0,1,1, 9,OP_LD,  0, 0,  9,10, 9, 0,0,0,0));
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk(0,0,0,0, 0,OP_ADD, i == 4, 10, 9,10, 9, 1,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 1, 9,  9,10, 9, 1,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0,  9,10, 9, 0,0,0,0));
        tbl.push_back(mk(0,0,1,1,11,OP_DIV, 0, 0, 11, 0, 0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 1,11, 11, 0,11, 1,0,1,1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0, 11, 0,11, 1,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0, 11, 0,11, 0,0,0,0));
        tbl.push_back(mk(0,0,1,1, 4,OP_SHF, 0, 0,  4, 0, 4, 0,0,0,0));
        tbl.push_back(mk(0,0,1,1, 4,OP_SHF, 0, 0,  4, 0, 4, 1,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0,  4, 0, 4, 1,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0,  4, 0, 4, 0,0,0,0));
        tbl.push_back(mk(1,0,1,1, 3,OP_MUL, 0, 0,  3, 0, 3, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0,  3, 0, 3, 0,0,0,0));
        tbl.push_back(mk(0,0,1,1, 5,OP_LD,  0, 0,  5, 6, 0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,1, 6,OP_MUL, 0, 0,  5, 6, 0, 1,0,0,1));
        tbl.push_back(mk(1,0,1,1, 7,OP_MUL, 1, 5,  5, 6, 0, 1,1,0,2));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0,  5, 6, 7, 0,0,0,0));
        tbl.push_back(mk(0,0,1,1,12,OP_LD,  0, 0, 12, 0, 0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 0,OP_ADD, 1,12, 12, 0,12, 1,0,1,1));
        tbl.push_back(mk(0,1,0,0, 0,OP_ADD, 0, 0, 12, 0,12, 0,0,0,0));
        tbl.push_back(mk(0,0,1,1, 0,OP_MUL, 1, 0,  0, 0, 0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0,  0, 0, 0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0,13,OP_MUL, 0, 0, 13, 0,13, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0, 13, 0,13, 0,0,0,0));
        tbl.push_back(mk(0,0,1,1,14,OP_ADD, 0, 0, 14, 0,14, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0, 14, 0,14, 0,0,0,0));
        tbl.push_back(mk(0,0,1,1, 1,OP_LD,  0, 0,  1, 2, 0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,1, 2,OP_LD,  0, 0,  1, 2, 0, 1,0,0,1));
        tbl.push_back(mk(0,0,1,1,31,OP_LD,  0, 0,  1, 2, 0, 1,1,0,2));
        tbl.push_back(mk(0,0,0,0, 0,OP_ADD, 0, 0, 31, 2, 1, 1,1,1,3));

        // Reset state, observed while rst is held.
        rst = 1; idle(); q_src1 = 5; q_src2 = 7; q_dest = 9;
        #2;
        chk("reset_p1", -1, 6'(q_p1), 0);
        chk("reset_waw", -1, 6'(q_waw), 0);
        chk("reset_busy", -1, busy_count, 0);
        @(negedge clk); rst = 0;

        foreach (tbl[i]) begin
            @(negedge clk);
            flush = tbl[i].fl; stall = tbl[i].st; iss_valid = tbl[i].iv; iss_dest_v = tbl[i].idv;
            iss_dest = tbl[i].id; iss_opcode = tbl[i].op; wb_valid = tbl[i].wv; wb_reg = tbl[i].wr;
            q_src1 = tbl[i].s1; q_src2 = tbl[i].s2; q_dest = tbl[i].d;
            #2;
            chk("q_p1", i, 6'(q_p1), 6'(tbl[i].p1));
            chk("q_p2", i, 6'(q_p2), 6'(tbl[i].p2));
            chk("q_waw", i, 6'(q_waw), 6'(tbl[i].w));
            chk("busy_count", i, busy_count, tbl[i].busy);
        end

        // Reset mid-operation: r1, r2, r31 still pending, add r5 with L=3.
        @(negedge clk); idle(); iss_valid = 1; iss_dest_v = 1; iss_dest = 5; iss_opcode = OP_MUL;
        @(negedge clk); idle(); q_src1 = 5; q_src2 = 31; q_dest = 5;
        #2;
        chk("pre_rst_p1", -2, 6'(q_p1), 1);
        chk("pre_rst_busy", -2, busy_count, 4);
        #1 rst = 1;
        #1;
        chk("async_rst_p1", -2, 6'(q_p1), 0);
        chk("async_rst_p2", -2, 6'(q_p2), 0);
        chk("async_rst_busy", -2, busy_count, 0);
        @(negedge clk); rst = 0;
        @(negedge clk); #2;
        chk("post_rst_busy", -2, busy_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
